instr_decode: RTL and testbench
===============================

// Module: instr_decode
// PURPOSE
//  RV32I decode stage, directly downstream of instruction fetch. Consumes IF_ID_Instr/IF_ID_PC.
//  Holds the 32x32 register file, decodes control, and generates immediates.
//  Detects load-use hazards and drives hz_IF_ID_Write/hz_PC_Write; resolves JAL in ID.
//  Registers everything into the ID/EX pipeline register.
// PARAMETERS
//  XLEN       32      datapath width
//  NOP_INSTR  32'h0   bubble encoding; decodes as all-control-zero
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   synchronous, active-high reset
//  IF_ID_Instr       in   32  instruction from fetch (0 = bubble)
//  IF_ID_PC          in   32  PC paired with IF_ID_Instr
//  ex_flush          in   1   branch taken or JALR resolved in EX; kill ID->EX this cycle
//  WB_RegWrite       in   1   writeback enable
//  WB_rd             in   5   writeback register index
//  WB_data           in   32  writeback data
//  hz_IF_ID_Write    out  1   0 = stall IF/ID (load-use)
//  hz_PC_Write       out  1   0 = hold PC (load-use)
//  cu_IF_flush       out  1   JAL decoded in ID; squash next fetched instr
//  cu_PCsrc          out  2   00 +4 | 10 JAL (combinational, ID-stage)
//  J_sign_extend     out  32  J-immediate of current instr, sign-extended
//  ID_EX_PC          out  32  registered PC
//  ID_EX_rs1_data    out  32  registered rs1 value
//  ID_EX_rs2_data    out  32  registered rs2 value
//  ID_EX_imm         out  32  registered sign-extended I/S/B/U immediate
//  ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out 5 each  registered register indices
//  ID_EX_funct3      out  3   registered funct3
//  ID_EX_ALUop       out  4   ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,LUI(pass B)
//  ID_EX_ALUSrc      out  1   1 = imm operand B
//  ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite, ID_EX_MemtoReg  out 1 each
//  ID_EX_Branch      out  1   conditional branch in EX
//  ID_EX_JARL        out  1   JALR in EX
//  ID_EX_PCsrc       out  2   01 branch | 11 JALR | 00 otherwise
// BEHAVIOUR
//  - Reset: all ID_EX_* outputs = 0; regfile x1..x31 = 0; hz_* = 1, cu_IF_flush = 0, cu_PCsrc = 00.
//  - Latency: one cycle, IF_ID_* to ID_EX_*. Decode, imm generation, regfile read and hazard logic are combinational.
//  - Regfile: x0 reads 0, writes to x0 are ignored. Write on posedge when WB_RegWrite.
//    Same-cycle write/read of the same rd (rd != 0) bypasses WB_data to the read.
//  - Load-use: stall = ID_EX_MemRead & ID_EX_rd != 0 & (rs1 used & rs1 == ID_EX_rd | rs2 used & rs2 == ID_EX_rd).
//    rs2 is used by R/S/B only; rs1 is unused by LUI/AUIPC/JAL.
//    On stall: hz_IF_ID_Write = 0, hz_PC_Write = 0, bubble into ID/EX. The stall is exactly one cycle.
//  - Bubble = all control fields 0, rd = 0. Data fields don't care (bench checks control only).
//  - Priority per edge: rst > ex_flush (bubble) > stall (bubble) > normal load.
//  - ex_flush and stall in the same cycle: bubble; hz_* still 0 (fetch flush dominates).
//  - JAL in ID (no flush, no stall): cu_PCsrc = 10, cu_IF_flush = 1.
//    ID/EX gets RegWrite = 1, ALU computes PC+4 (ALUSrc = imm 4, operand A = PC), PCsrc = 00.
//    JAL suppressed (cu_* idle) when ex_flush = 1.
//  - AUIPC: operand A = PC; ALUop ADD, imm = U. Operand A select is encoded as rs1 = 0 with a PC flag folded into ALUop-A mux.
//  - Unknown opcode and all-zero instr: decoded as bubble, no exception.
//  - Immediates: I {20{i[31]},i[31:20]}; S uses i[31:25],i[11:7]; B {i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0};
//    J {i[31],i[19:12],i[20],i[30:21],0}. All sign-extended to 32.
// TESTING
//  - Reset: rst = 1 for 2 clk -> all ID_EX_* = 0, hz_IF_ID_Write = 1; read x5 -> 0.
//  - Regfile bypass: WB writes x3 = 32'hDEAD_BEEF while IF_ID = add x4,x3,x0 -> ID_EX_rs1_data = DEADBEEF next edge.
//  - Load-use: lw x6,0(x2) then add x7,x6,x1 -> 1 cycle with hz_* = 0 and an ID/EX bubble, then add issues.
//    Case lw to x0 -> no stall.
//  - JAL: jal x1,+16 at PC 0x40 -> cu_PCsrc = 10, J_sign_extend = 16, cu_IF_flush = 1.
//    Next: ID_EX_RegWrite = 1, ID_EX_rd = 1.
//  - Flush: beq in EX with ex_flush = 1 while IF_ID holds sw -> ID_EX_MemWrite = 0 next cycle.
//    JAL in ID during ex_flush -> cu_PCsrc = 00.
//  - Imm sweep: B-type with i[31] = 1 -> ID_EX_imm[31:12] all 1, bit 0 = 0; x0 write attempt -> x0 reads 0.

Source files
------------

// File: rtl/instr_decode.sv
// RV32I decode stage: register file, control decode, immediate generation,
// load-use hazard detection, JAL redirect in ID and the ID/EX pipeline register.
module instr_decode #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     IF_ID_Instr,
    input  logic [31:0]     IF_ID_PC,
    input  logic            ex_flush,
    input  logic            WB_RegWrite,
    input  logic [4:0]      WB_rd,
    input  logic [XLEN-1:0] WB_data,
    output logic            hz_IF_ID_Write,
    output logic            hz_PC_Write,
    output logic            cu_IF_flush,
    output logic [1:0]      cu_PCsrc,
    output logic [31:0]     J_sign_extend,
    output logic [31:0]     ID_EX_PC,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [31:0]     ID_EX_imm,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [2:0]      ID_EX_funct3,
    output logic [3:0]      ID_EX_ALUop,
    output logic            ID_EX_ALUSrc,
    output logic            ID_EX_MemRead,
    output logic            ID_EX_MemWrite,
    output logic            ID_EX_RegWrite,
    output logic            ID_EX_MemtoReg,
    output logic            ID_EX_Branch,
    output logic            ID_EX_JARL,
    output logic [1:0]      ID_EX_PCsrc
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // ALU_ADDPC selects PC as operand A (AUIPC, JAL link); all others use rs1.
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;
    localparam logic [3:0] ALU_ADDPC = 4'd11;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_nop;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]      alu_op;
    logic            alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic            branch, jalr, is_jal;
    logic [1:0]      pc_src;
    logic [31:0]     imm;
    logic            rs1_used, rs2_used, rd_used;
    logic [4:0]      rs1_idx, rs2_idx, rd_idx;

    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            stall;
    logic            jal_take;

    assign instr  = IF_ID_Instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign is_nop = (instr == NOP_INSTR);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Control decode and immediate select; unknown opcodes fall through as a bubble.
    always_comb begin
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jalr       = 1'b0;
        is_jal     = 1'b0;
        pc_src     = 2'b00;
        imm        = 32'h0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        rd_used    = 1'b0;
        if (!is_nop) begin
            case (opcode)
                OP_REG: begin
                    rs1_used  = 1'b1;
                    rs2_used  = 1'b1;
                    rd_used   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = alu_decode(funct3, instr[30]);
                end
                OP_IMM: begin
                    rs1_used  = 1'b1;
                    rd_used   = 1'b1;
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    imm       = imm_i;
                    // bit 30 only distinguishes SRAI; ADDI with it set is still ADD
                    alu_op    = alu_decode(funct3, instr[30] && (funct3 == 3'b101));
                end
                OP_LOAD: begin
                    rs1_used   = 1'b1;
                    rd_used    = 1'b1;
                    reg_write  = 1'b1;
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                    imm        = imm_i;
                end
                OP_STORE: begin
                    rs1_used  = 1'b1;
                    rs2_used  = 1'b1;
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm       = imm_s;
                end
                OP_BRANCH: begin
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                    branch   = 1'b1;
                    pc_src   = 2'b01;
                    alu_op   = ALU_SUB;
                    imm      = imm_b;
                end
                OP_JALR: begin
                    rs1_used  = 1'b1;
                    rd_used   = 1'b1;
                    reg_write = 1'b1;
                    jalr      = 1'b1;
                    pc_src    = 2'b11;
                    alu_src   = 1'b1;
                    imm       = imm_i;
                end
                OP_LUI: begin
                    rd_used   = 1'b1;
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    alu_op    = ALU_LUI;
                    imm       = imm_u;
                end
                OP_AUIPC: begin
                    rd_used   = 1'b1;
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    alu_op    = ALU_ADDPC;
                    imm       = imm_u;
                end
                OP_JAL: begin
                    // target is taken in ID; EX only produces the link value PC+4
                    is_jal    = 1'b1;
                    rd_used   = 1'b1;
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    alu_op    = ALU_ADDPC;
                    imm       = 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign rs1_idx = rs1_used ? instr[19:15] : 5'd0;
    assign rs2_idx = rs2_used ? instr[24:20] : 5'd0;
    assign rd_idx  = rd_used  ? instr[11:7]  : 5'd0;

    // Register file write port; x0 is never written and reads back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (WB_RegWrite && (WB_rd != 5'd0)) begin
            regs[WB_rd] <= WB_data;
        end
    end

    // Read ports with same-cycle writeback bypass.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_idx != 5'd0)
            rs1_data = (WB_RegWrite && (WB_rd == rs1_idx)) ? WB_data : regs[rs1_idx];
        if (rs2_idx != 5'd0)
            rs2_data = (WB_RegWrite && (WB_rd == rs2_idx)) ? WB_data : regs[rs2_idx];
    end

    // Load-use: the stalled instruction re-decodes next cycle against a bubble,
    // so the stall can never last more than one cycle.
    assign stall = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                   ((rs1_used && (instr[19:15] == ID_EX_rd)) ||
                    (rs2_used && (instr[24:20] == ID_EX_rd)));

    assign hz_IF_ID_Write = ~stall;
    assign hz_PC_Write    = ~stall;
    assign jal_take       = is_jal && !ex_flush && !stall;
    assign cu_IF_flush    = jal_take;
    assign cu_PCsrc       = jal_take ? 2'b10 : 2'b00;
    assign J_sign_extend  = imm_j;

    // ID/EX register; reset, flush and stall all load an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || ex_flush || stall) begin
            ID_EX_PC       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_funct3   <= '0;
            ID_EX_ALUop    <= '0;
            ID_EX_ALUSrc   <= 1'b0;
            ID_EX_MemRead  <= 1'b0;
            ID_EX_MemWrite <= 1'b0;
            ID_EX_RegWrite <= 1'b0;
            ID_EX_MemtoReg <= 1'b0;
            ID_EX_Branch   <= 1'b0;
            ID_EX_JARL     <= 1'b0;
            ID_EX_PCsrc    <= 2'b00;
        end else begin
            ID_EX_PC       <= IF_ID_PC;
            ID_EX_rs1_data <= rs1_data;
            ID_EX_rs2_data <= rs2_data;
            ID_EX_imm      <= imm;
            ID_EX_rs1      <= rs1_idx;
            ID_EX_rs2      <= rs2_idx;
            ID_EX_rd       <= rd_idx;
            ID_EX_funct3   <= is_nop ? 3'b000 : funct3;
            ID_EX_ALUop    <= alu_op;
            ID_EX_ALUSrc   <= alu_src;
            ID_EX_MemRead  <= mem_read;
            ID_EX_MemWrite <= mem_write;
            ID_EX_RegWrite <= reg_write;
            ID_EX_MemtoReg <= mem_to_reg;
            ID_EX_Branch   <= branch;
            ID_EX_JARL     <= jalr;
            ID_EX_PCsrc    <= pc_src;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: decode vector table plus hand-written
// sequences for reset, regfile bypass, load-use stall, JAL and flush.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_ID_Instr, IF_ID_PC;
    logic        ex_flush, WB_RegWrite;
    logic [4:0]  WB_rd;
    logic [31:0] WB_data;
    logic        hz_IF_ID_Write, hz_PC_Write, cu_IF_flush;
    logic [1:0]  cu_PCsrc;
    logic [31:0] J_sign_extend, ID_EX_PC, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]  ID_EX_funct3;
    logic [3:0]  ID_EX_ALUop;
    logic        ID_EX_ALUSrc, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite;
    logic        ID_EX_MemtoReg, ID_EX_Branch, ID_EX_JARL;
    logic [1:0]  ID_EX_PCsrc;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_decode dut (
        .clk(clk), .rst(rst), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC(IF_ID_PC),
        .ex_flush(ex_flush), .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd), .WB_data(WB_data),
        .hz_IF_ID_Write(hz_IF_ID_Write), .hz_PC_Write(hz_PC_Write),
        .cu_IF_flush(cu_IF_flush), .cu_PCsrc(cu_PCsrc), .J_sign_extend(J_sign_extend),
        .ID_EX_PC(ID_EX_PC), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_funct3(ID_EX_funct3), .ID_EX_ALUop(ID_EX_ALUop), .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
        .ID_EX_Branch(ID_EX_Branch), .ID_EX_JARL(ID_EX_JARL), .ID_EX_PCsrc(ID_EX_PCsrc)
    );

    always #5 clk = ~clk;

    // flags order: {ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch, JARL}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [6:0]  flags;
        logic [1:0]  pcsrc;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] ctrl_word();
        return {ID_EX_ALUop, ID_EX_ALUSrc, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_RegWrite,
                ID_EX_MemtoReg, ID_EX_Branch, ID_EX_JARL, ID_EX_PCsrc};
    endfunction

    localparam logic [12:0] CTRL_BUBBLE = 13'h0;
    localparam logic [12:0] CTRL_RTYPE_ADD = {4'd0, 7'b0001000, 2'b00};
    localparam logic [12:0] CTRL_JAL = {4'd11, 7'b1001000, 2'b00};

    initial begin
        vecs[0]  = '{"add",   enc_r(7'h00, 5'd14, 5'd13, 3'd0, 5'd12, 7'h33), 4'd0,  7'b0001000, 2'b00, 32'h0,        5'd13, 5'd14, 5'd12};
        vecs[1]  = '{"sub",   enc_r(7'h20, 5'd7,  5'd6,  3'd0, 5'd5,  7'h33), 4'd1,  7'b0001000, 2'b00, 32'h0,        5'd6,  5'd7,  5'd5};
        vecs[2]  = '{"sra",   enc_r(7'h20, 5'd3,  5'd2,  3'd5, 5'd1,  7'h33), 4'd7,  7'b0001000, 2'b00, 32'h0,        5'd2,  5'd3,  5'd1};
        vecs[3]  = '{"sltu",  enc_r(7'h00, 5'd11, 5'd10, 3'd3, 5'd9,  7'h33), 4'd4,  7'b0001000, 2'b00, 32'h0,        5'd10, 5'd11, 5'd9};
        vecs[4]  = '{"addi",  enc_i(12'hFFF, 5'd1, 3'd0, 5'd8, 7'h13),        4'd0,  7'b1001000, 2'b00, 32'hFFFF_FFFF, 5'd1,  5'd0,  5'd8};
        vecs[5]  = '{"srai",  enc_i(12'h404, 5'd3, 3'd5, 5'd2, 7'h13),        4'd7,  7'b1001000, 2'b00, 32'h0000_0404, 5'd3,  5'd0,  5'd2};
        vecs[6]  = '{"srli",  enc_i(12'h003, 5'd2, 3'd5, 5'd1, 7'h13),        4'd6,  7'b1001000, 2'b00, 32'h0000_0003, 5'd2,  5'd0,  5'd1};
        vecs[7]  = '{"andi",  enc_i(12'h7FF, 5'd4, 3'd7, 5'd3, 7'h13),        4'd9,  7'b1001000, 2'b00, 32'h0000_07FF, 5'd4,  5'd0,  5'd3};
        vecs[8]  = '{"lw",    enc_i(12'h008, 5'd2, 3'd2, 5'd6, 7'h03),        4'd0,  7'b1101100, 2'b00, 32'h0000_0008, 5'd2,  5'd0,  5'd6};
        vecs[9]  = '{"sw",    enc_s(12'hFFC, 5'd5, 5'd2, 3'd2),               4'd0,  7'b1010000, 2'b00, 32'hFFFF_FFFC, 5'd2,  5'd5,  5'd0};
        vecs[10] = '{"beq",   enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0),              4'd1,  7'b0000010, 2'b01, 32'hFFFF_FFF8, 5'd1,  5'd2,  5'd0};
        vecs[11] = '{"bne",   enc_b(13'h07FE, 5'd4, 5'd3, 3'd1),              4'd1,  7'b0000010, 2'b01, 32'h0000_07FE, 5'd3,  5'd4,  5'd0};
        vecs[12] = '{"lui",   enc_u(20'h12345, 5'd7, 7'h37),                  4'd10, 7'b1001000, 2'b00, 32'h1234_5000, 5'd0,  5'd0,  5'd7};
        vecs[13] = '{"auipc", enc_u(20'h80000, 5'd8, 7'h17),                  4'd11, 7'b1001000, 2'b00, 32'h8000_0000, 5'd0,  5'd0,  5'd8};
        vecs[14] = '{"jalr",  enc_i(12'h00C, 5'd5, 3'd0, 5'd1, 7'h67),        4'd0,  7'b1001001, 2'b11, 32'h0000_000C, 5'd5,  5'd0,  5'd1};
        vecs[15] = '{"unknown", 32'hFFFF_FFFF,                                4'd0,  7'b0000000, 2'b00, 32'h0,        5'd0,  5'd0,  5'd0};
        vecs[16] = '{"nop",   32'h0000_0000,                                  4'd0,  7'b0000000, 2'b00, 32'h0,        5'd0,  5'd0,  5'd0};

        rst = 1'b1; IF_ID_Instr = 32'h0; IF_ID_PC = 32'h0; ex_flush = 1'b0;
        WB_RegWrite = 1'b0; WB_rd = 5'd0; WB_data = 32'h0;

        // reset
        tick(); tick();
        check("rst_ctrl", 32'(ctrl_word()), 32'(CTRL_BUBBLE));
        check("rst_rd", 32'(ID_EX_rd), 32'h0);
        check("rst_pc", ID_EX_PC, 32'h0);
        check("rst_hz_ifid", 32'(hz_IF_ID_Write), 32'h1);
        check("rst_hz_pc", 32'(hz_PC_Write), 32'h1);
        check("rst_cu", 32'({cu_IF_flush, cu_PCsrc}), 32'h0);
        rst = 1'b0;
        IF_ID_Instr = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd4, 7'h33);
        tick();
        check("read_x5", ID_EX_rs1_data, 32'h0);

        // decode table
        for (int i = 0; i < NVEC; i++) begin
            IF_ID_Instr = vecs[i].instr;
            IF_ID_PC = 32'h100 + 32'(i) * 4;
            tick();
            check({vecs[i].name, "_ctrl"}, 32'(ctrl_word()), 32'({vecs[i].alu, vecs[i].flags, vecs[i].pcsrc}));
            check({vecs[i].name, "_imm"}, ID_EX_imm, vecs[i].imm);
            check({vecs[i].name, "_rd"}, 32'(ID_EX_rd), 32'(vecs[i].rd));
            check({vecs[i].name, "_rs"}, 32'({ID_EX_rs1, ID_EX_rs2}), 32'({vecs[i].rs1, vecs[i].rs2}));
            check({vecs[i].name, "_pc"}, ID_EX_PC, 32'h100 + 32'(i) * 4);
            IF_ID_Instr = 32'h0;
            tick();
        end

        // regfile bypass and storage
        WB_RegWrite = 1'b1; WB_rd = 5'd3; WB_data = 32'hDEAD_BEEF;
        IF_ID_Instr = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4, 7'h33);
        tick();
        check("bypass_rs1", ID_EX_rs1_data, 32'hDEAD_BEEF);
        WB_RegWrite = 1'b0;
        IF_ID_Instr = enc_r(7'h00, 5'd3, 5'd0, 3'd0, 5'd4, 7'h33);
        tick();
        check("stored_rs2", ID_EX_rs2_data, 32'hDEAD_BEEF);
        check("x0_rs1", ID_EX_rs1_data, 32'h0);
        WB_RegWrite = 1'b1; WB_rd = 5'd0; WB_data = 32'h1234_5678;
        IF_ID_Instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4, 7'h33);
        tick();
        check("x0_bypass", ID_EX_rs1_data, 32'h0);
        WB_RegWrite = 1'b0;
        tick();
        check("x0_stored", ID_EX_rs1_data, 32'h0);

        // load-use on rs1
        IF_ID_Instr = enc_i(12'h000, 5'd2, 3'd2, 5'd6, 7'h03);
        tick();
        check("lu_memread", 32'(ID_EX_MemRead), 32'h1);
        IF_ID_Instr = enc_r(7'h00, 5'd1, 5'd6, 3'd0, 5'd7, 7'h33);
        #1;
        check("lu_hz_ifid", 32'(hz_IF_ID_Write), 32'h0);
        check("lu_hz_pc", 32'(hz_PC_Write), 32'h0);
        tick();
        check("lu_bubble_ctrl", 32'(ctrl_word()), 32'(CTRL_BUBBLE));
        check("lu_bubble_rd", 32'(ID_EX_rd), 32'h0);
        check("lu_release", 32'({hz_IF_ID_Write, hz_PC_Write}), 32'h3);
        tick();
        check("lu_issue_rd", 32'(ID_EX_rd), 32'd7);
        check("lu_issue_ctrl", 32'(ctrl_word()), 32'(CTRL_RTYPE_ADD));

        // load-use on rs2 (store data)
        IF_ID_Instr = enc_i(12'h000, 5'd2, 3'd2, 5'd6, 7'h03);
        tick();
        IF_ID_Instr = enc_s(12'h000, 5'd6, 5'd2, 3'd2);
        #1;
        check("lu_rs2_hz", 32'(hz_PC_Write), 32'h0);
        tick();
        check("lu_rs2_bubble", 32'(ctrl_word()), 32'(CTRL_BUBBLE));

        // I-type whose imm bits alias rs2 = x6 must not stall
        IF_ID_Instr = enc_i(12'h000, 5'd2, 3'd2, 5'd6, 7'h03);
        tick();
        IF_ID_Instr = enc_i(12'h006, 5'd1, 3'd0, 5'd7, 7'h13);
        #1;
        check("noalias_hz", 32'(hz_IF_ID_Write), 32'h1);
        tick();
        check("noalias_rd", 32'(ID_EX_rd), 32'd7);

        // load to x0 never stalls
        IF_ID_Instr = enc_i(12'h000, 5'd2, 3'd2, 5'd0, 7'h03);
        tick();
        IF_ID_Instr = enc_r(7'h00, 5'd1, 5'd0, 3'd0, 5'd7, 7'h33);
        #1;
        check("lw_x0_hz", 32'(hz_IF_ID_Write), 32'h1);
        tick();
        check("lw_x0_rd", 32'(ID_EX_rd), 32'd7);

        // JAL resolved in ID
        IF_ID_Instr = enc_j(21'h000010, 5'd1);
        IF_ID_PC = 32'h40;
        #1;
        check("jal_pcsrc", 32'(cu_PCsrc), 32'h2);
        check("jal_jimm", J_sign_extend, 32'd16);
        check("jal_flush", 32'(cu_IF_flush), 32'h1);
        tick();
        check("jal_ctrl", 32'(ctrl_word()), 32'(CTRL_JAL));
        check("jal_rd", 32'(ID_EX_rd), 32'd1);
        check("jal_link", {ID_EX_imm[15:0], ID_EX_PC[15:0]}, 32'h0004_0040);
        IF_ID_Instr = enc_j(21'h1FFFFC, 5'd0);
        #1;
        check("jal_neg_jimm", J_sign_extend, 32'hFFFF_FFFC);

        // flush
        IF_ID_Instr = enc_s(12'hFFC, 5'd5, 5'd2, 3'd2);
        ex_flush = 1'b1;
        tick();
        check("flush_memwrite", 32'(ID_EX_MemWrite), 32'h0);
        check("flush_ctrl", 32'(ctrl_word()), 32'(CTRL_BUBBLE));
        IF_ID_Instr = enc_j(21'h000010, 5'd1);
        #1;
        check("flush_jal_pcsrc", 32'(cu_PCsrc), 32'h0);
        check("flush_jal_ifflush", 32'(cu_IF_flush), 32'h0);
        ex_flush = 1'b0;

        // flush and stall together
        IF_ID_Instr = enc_i(12'h000, 5'd2, 3'd2, 5'd6, 7'h03);
        tick();
        IF_ID_Instr = enc_r(7'h00, 5'd1, 5'd6, 3'd0, 5'd7, 7'h33);
        ex_flush = 1'b1;
        #1;
        check("fs_hz", 32'({hz_IF_ID_Write, hz_PC_Write}), 32'h0);
        tick();
        check("fs_bubble", 32'({ctrl_word(), 3'b000, ID_EX_rd}), 32'h0);
        ex_flush = 1'b0;
        IF_ID_Instr = 32'h0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
